// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the scpu pipelined control unit:
//   - RV opcode constants seen by the ID-stage decoder
//   - mem_to_reg write-back source encodings
//   - control bundle widths and packed bundle structs (EX / MEM / WB)
//   - the all-zero BUBBLE bundle used for flushes and stalls
//   - the control state machine encoding
//   - a helper that evaluates the load-use hazard condition
// ---------------------------------------------------------------------------
package ctrl_pkg;

   // Major opcodes, instruction[6:0]
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

   // funct7 value that marks an M-extension (MUL/DIV) R-type instruction
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // funct3 of BEQ; b_type distinguishes it from the other branch kinds
   localparam logic [2:0] FUNCT3_BEQ    = 3'b000;

   // ALU operation used by all conditional branches (compare)
   localparam logic [3:0] ALU_OP_BRANCH = 4'b1000;

   // Write-back source select
   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_IMM = 2'b01;
   localparam logic [1:0] M2R_PC4 = 2'b10;
   localparam logic [1:0] M2R_MEM = 2'b11;

   // Bundle widths as they appear on the top-level ports
   localparam int EX_CTRL_W  = 6;
   localparam int MEM_CTRL_W = 3;
   localparam int WB_CTRL_W  = 3;
   localparam int REG_IDX_W  = 5;

   typedef struct packed {
      logic       is_muldiv;
      logic       alu_src_b;
      logic [3:0] alu_op;
   } ex_ctrl_t;

   typedef struct packed {
      logic branch;
      logic b_type;
      logic mem_write;
   } mem_ctrl_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] mem_to_reg;
   } wb_ctrl_t;

   // Everything an instruction needs from EX onwards
   typedef struct packed {
      ex_ctrl_t  ex;
      mem_ctrl_t m;
      wb_ctrl_t  wb;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t BUBBLE = '0;

   typedef enum logic {
      ST_RUN,
      ST_MD_BUSY
   } state_t;

   // A load sitting in EX whose destination feeds the ID instruction
   // cannot forward in time; x0 never creates a dependency.
   function automatic logic is_load_use(
      input wb_ctrl_t             ex_wb,
      input logic [REG_IDX_W-1:0] ex_rd,
      input logic [REG_IDX_W-1:0] rs1,
      input logic [REG_IDX_W-1:0] rs2
   );
      return ex_wb.reg_write && (ex_wb.mem_to_reg == M2R_MEM) &&
             (ex_rd != '0) && ((ex_rd == rs1) || (ex_rd == rs2));
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational ID-stage decoder. Turns the opcode/funct fields into
// the EX, MEM and WB control bundles.
// Ports:
//   id_valid  in  1 : ID holds a real instruction
//   op_code   in  7 : instruction[6:0]
//   funct3    in  3 : instruction[14:12]
//   funct7    in  7 : instruction[31:25]
//   ex_dec    out   : EX bundle {is_muldiv, alu_src_b, alu_op}
//   mem_dec   out   : MEM bundle {branch, b_type, mem_write}
//   wb_dec    out   : WB bundle {reg_write, mem_to_reg}
//   dec_valid out 1 : recognised opcode with id_valid=1 (rd is meaningful)
// ---------------------------------------------------------------------------
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic      id_valid,
   input  logic [6:0] op_code,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output ex_ctrl_t  ex_dec,
   output mem_ctrl_t mem_dec,
   output wb_ctrl_t  wb_dec,
   output logic      dec_valid
);

   // Start from an all-zero bubble; each recognised opcode sets only the
   // fields it needs. Unknown opcodes and empty ID slots stay a bubble.
   always_comb begin
      ex_dec    = '0;
      mem_dec   = '0;
      wb_dec    = '0;
      dec_valid = 1'b0;

      if (id_valid) begin
         dec_valid = 1'b1;
         case (op_code)
            OPC_OP_IMM: begin
               wb_dec.reg_write  = 1'b1;
               ex_dec.alu_src_b  = 1'b1;
               ex_dec.alu_op     = {1'b0, funct3};
               wb_dec.mem_to_reg = M2R_ALU;
            end
            OPC_OP: begin
               wb_dec.reg_write  = 1'b1;
               ex_dec.alu_op     = {funct7[5], funct3};
               wb_dec.mem_to_reg = M2R_ALU;
               // M-extension ops take the multi-cycle unit; funct3 selects
               // which MUL/DIV variant.
               if (ENABLE_M && (funct7 == FUNCT7_MULDIV)) begin
                  ex_dec.is_muldiv = 1'b1;
                  ex_dec.alu_op    = {1'b0, funct3};
               end
            end
            OPC_LOAD: begin
               wb_dec.reg_write  = 1'b1;
               ex_dec.alu_src_b  = 1'b1;
               wb_dec.mem_to_reg = M2R_MEM;
            end
            OPC_STORE: begin
               ex_dec.alu_src_b  = 1'b1;
               mem_dec.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
               mem_dec.branch = 1'b1;
               mem_dec.b_type = (funct3 == FUNCT3_BEQ);
               ex_dec.alu_op  = ALU_OP_BRANCH;
            end
            OPC_LUI: begin
               wb_dec.reg_write  = 1'b1;
               ex_dec.alu_src_b  = 1'b1;
               wb_dec.mem_to_reg = M2R_IMM;
            end
            OPC_AUIPC: begin
               wb_dec.reg_write  = 1'b1;
               ex_dec.alu_src_b  = 1'b1;
               wb_dec.mem_to_reg = M2R_ALU;
            end
            OPC_JAL: begin
               wb_dec.reg_write  = 1'b1;
               wb_dec.mem_to_reg = M2R_PC4;
            end
            OPC_JALR: begin
               wb_dec.reg_write  = 1'b1;
               ex_dec.alu_src_b  = 1'b1;
               wb_dec.mem_to_reg = M2R_PC4;
            end
            OPC_SYSTEM: begin
               wb_dec.reg_write  = 1'b1;
               wb_dec.mem_to_reg = M2R_ALU;
            end
            OPC_OP_32: begin
               wb_dec.reg_write = 1'b1;
               ex_dec.alu_op    = {1'b1, funct3};
            end
            OPC_OP_IMM_32: begin
               wb_dec.reg_write = 1'b1;
               ex_dec.alu_src_b = 1'b1;
               ex_dec.alu_op    = {1'b1, funct3};
            end
            default: begin
               dec_valid = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe
// Pipelined control unit for the scpu datapath. Decodes the ID instruction,
// carries control bundles and destination registers through the EX, MEM
// and WB stage registers, inserts load-use bubbles, squashes on branch/jump
// flush, and holds the pipeline while a MUL/DIV occupies EX.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   id_valid          : ID holds a real instruction
//   op_code/funct3/7  : ID instruction fields
//   id_rs1/rs2/rd     : ID register indices
//   flush             : taken branch/jump resolved in EX
//   stall             : hold PC and IF/ID (combinational)
//   ex_ctrl           : EX stage {is_muldiv, alu_src_b, alu_op[3:0]}
//   mem_ctrl          : MEM stage {branch, b_type, mem_write}
//   wb_ctrl           : WB stage {reg_write, mem_to_reg[1:0]}
//   ex_rd/mem_rd/wb_rd: destination register per stage
//   muldiv_busy       : MUL/DIV sequencer counting
// ---------------------------------------------------------------------------
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int unsigned MULDIV_LAT = 4,
   parameter bit          ENABLE_M   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [6:0] op_code,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic [4:0] id_rd,
   input  logic       flush,
   output logic       stall,
   output logic [5:0] ex_ctrl,
   output logic [2:0] mem_ctrl,
   output logic [2:0] wb_ctrl,
   output logic [4:0] ex_rd,
   output logic [4:0] mem_rd,
   output logic [4:0] wb_rd,
   output logic       muldiv_busy
);

   // Counter only needs to hold MULDIV_LAT-1
   localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   ex_ctrl_t  ex_dec;
   mem_ctrl_t mem_dec;
   wb_ctrl_t  wb_dec;
   logic      dec_valid;

   ctrl_bundle_t  ex_bundle_q, ex_bundle_d;
   logic [4:0]    ex_rd_q, ex_rd_d;
   mem_ctrl_t     mem_m_q, mem_m_d;
   wb_ctrl_t      mem_wb_q, mem_wb_d;
   logic [4:0]    mem_rd_q, mem_rd_d;
   wb_ctrl_t      wb_wb_q, wb_wb_d;
   logic [4:0]    wb_rd_q, wb_rd_d;
   state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic load_use;

   ctrl_decode #(
      .ENABLE_M (ENABLE_M)
   ) u_decode (
      .id_valid  (id_valid),
      .op_code   (op_code),
      .funct3    (funct3),
      .funct7    (funct7),
      .ex_dec    (ex_dec),
      .mem_dec   (mem_dec),
      .wb_dec    (wb_dec),
      .dec_valid (dec_valid)
   );

   assign load_use = is_load_use(ex_bundle_q.wb, ex_rd_q, id_rs1, id_rs2);

   // Next-state for the stage registers and the RUN/MD_BUSY sequencer.
   // Default is normal flow: MEM takes EX, WB takes MEM, EX holds.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ex_bundle_d = ex_bundle_q;
      ex_rd_d     = ex_rd_q;
      mem_m_d     = ex_bundle_q.m;
      mem_wb_d    = ex_bundle_q.wb;
      mem_rd_d    = ex_rd_q;
      wb_wb_d     = mem_wb_q;
      wb_rd_d     = mem_rd_q;
      stall       = 1'b0;
      muldiv_busy = 1'b0;

      case (state_q)
         ST_RUN: begin
            // Flush wins over load-use: the dependent instruction in ID is
            // on the wrong path anyway, so no stall is needed.
            if (flush) begin
               ex_bundle_d = BUBBLE;
               ex_rd_d     = '0;
            end else if (load_use) begin
               stall       = 1'b1;
               ex_bundle_d = BUBBLE;
               ex_rd_d     = '0;
            end else begin
               ex_bundle_d = '{ex: ex_dec, m: mem_dec, wb: wb_dec};
               ex_rd_d     = dec_valid ? id_rd : '0;
               if (ex_dec.is_muldiv && (MULDIV_LAT > 1)) begin
                  state_d = ST_MD_BUSY;
                  cnt_d   = CNT_LOAD;
               end
            end
         end

         ST_MD_BUSY: begin
            // EX is occupied by the muldiv; flush is ignored because the
            // instruction in EX cannot be a branch.
            stall       = 1'b1;
            muldiv_busy = 1'b1;
            cnt_d       = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               // Release the muldiv into MEM. ID is still held this cycle,
               // so EX takes a bubble and the held instruction enters EX
               // on the next RUN cycle.
               state_d     = ST_RUN;
               ex_bundle_d = BUBBLE;
               ex_rd_d     = '0;
            end else begin
               mem_m_d  = '0;
               mem_wb_d = '0;
               mem_rd_d = '0;
            end
         end

         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Stage and sequencer registers; reset drops any in-flight muldiv.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         ex_bundle_q <= BUBBLE;
         ex_rd_q     <= '0;
         mem_m_q     <= '0;
         mem_wb_q    <= '0;
         mem_rd_q    <= '0;
         wb_wb_q     <= '0;
         wb_rd_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ex_bundle_q <= ex_bundle_d;
         ex_rd_q     <= ex_rd_d;
         mem_m_q     <= mem_m_d;
         mem_wb_q    <= mem_wb_d;
         mem_rd_q    <= mem_rd_d;
         wb_wb_q     <= wb_wb_d;
         wb_rd_q     <= wb_rd_d;
      end
   end

   assign ex_ctrl  = ex_bundle_q.ex;
   assign mem_ctrl = mem_m_q;
   assign wb_ctrl  = wb_wb_q;
   assign ex_rd    = ex_rd_q;
   assign mem_rd   = mem_rd_q;
   assign wb_rd    = wb_rd_q;

endmodule
